// File: rtl/b2s_pkg.sv
// b2s_pkg: FSM state encoding and line timing shared by the b2s transmitter and receiver
package b2s_pkg;
  localparam logic [2:0] S_HUNT       = 3'd0;
  localparam logic [2:0] S_WAIT_START = 3'd1;
  localparam logic [2:0] S_START_LOW  = 3'd2;
  localparam logic [2:0] S_BIT_HIGH   = 3'd3;
  localparam logic [2:0] S_BIT_LOW    = 3'd4;
  localparam int B2S_START_LOW  = 20;
  localparam int B2S_START_HIGH = 20;
  localparam int B2S_ONE_LOW    = 18;
  localparam int B2S_ONE_HIGH   = 149;
  localparam int B2S_ZERO_LOW   = 136;
  localparam int B2S_ZERO_HIGH  = 31;
  localparam int B2S_THRESH     = 77;
  localparam int B2S_IDLE_CYC   = 500;
  localparam int B2S_MAX_LOW    = 400;
endpackage

// File: rtl/b2s_sync_edge.sv
// b2s_sync_edge: two-flop synchronizer plus a registered line with aligned rise/fall pulses
module b2s_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic line,
  output logic rise,
  output logic fall
);
  logic [1:0] sync;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync <= '1;
      line <= 1'b1;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[0], din};
      line <= sync[1];
      rise <= sync[1] & ~line;
      fall <= ~sync[1] & line;
    end
endmodule

// File: rtl/b2s_receiver.sv
// b2s_receiver: decodes pulse-length b2s frames (short low = 1, long low = 0) into LSB-first words
module b2s_receiver
  import b2s_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int THRESH   = B2S_THRESH,
  parameter int IDLE_CYC = B2S_IDLE_CYC,
  parameter int MAX_LOW  = B2S_MAX_LOW,
  parameter int CNT_W    = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             b2s_din,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             frame_err,
  output logic             busy
);
  localparam int IW = $clog2(WIDTH);
  logic             line, rise, fall;
  logic [2:0]       state;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] sh, sh_nxt;
  logic             bit_val, low_max, high_max, err, done;
  b2s_sync_edge u_sync (.clk(clk), .rst_n(rst_n), .din(b2s_din), .line(line), .rise(rise), .fall(fall));
  assign cnt_inc  = &cnt ? cnt : cnt + 1'b1;
  assign bit_val  = cnt < CNT_W'(THRESH);
  assign sh_nxt   = {bit_val, sh[WIDTH-1:1]};
  assign low_max  = cnt == CNT_W'(MAX_LOW - 1);
  assign high_max = cnt == CNT_W'(IDLE_CYC - 1);
  // a short start pulse decodes like a 1, so the same compare qualifies it
  assign err = (state == S_START_LOW && (rise ? !bit_val : low_max)) ||
               (state == S_BIT_HIGH && !fall && high_max) ||
               (state == S_BIT_LOW && !rise && low_max);
  assign done = state == S_BIT_LOW && rise && idx == IW'(WIDTH - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= S_HUNT;
      cnt        <= '0;
      idx        <= '0;
      sh         <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      dout_valid <= done;
      frame_err  <= err;
      if (err || done) begin
        state <= S_HUNT;
        cnt   <= '0;
        idx   <= '0;
        sh    <= '0;
        busy  <= 1'b0;
        if (done) dout <= sh_nxt;
      end else
        case (state)
          S_HUNT: begin
            cnt <= line ? cnt_inc : '0;
            if (line && high_max) state <= S_WAIT_START;
          end
          S_WAIT_START:
            if (fall) begin
              cnt   <= CNT_W'(1);
              busy  <= 1'b1;
              state <= S_START_LOW;
            end
          S_START_LOW:
            if (rise) begin
              cnt   <= CNT_W'(1);
              idx   <= '0;
              state <= S_BIT_HIGH;
            end else cnt <= cnt_inc;
          S_BIT_HIGH:
            if (fall) begin
              cnt   <= CNT_W'(1);
              state <= S_BIT_LOW;
            end else cnt <= cnt_inc;
          S_BIT_LOW:
            if (rise) begin
              sh    <= sh_nxt;
              idx   <= idx + 1'b1;
              cnt   <= CNT_W'(1);
              state <= S_BIT_HIGH;
            end else cnt <= cnt_inc;
          default: state <= S_HUNT;
        endcase
    end
endmodule

// File: tb/tb_b2s_receiver.sv
// tb_b2s_receiver: randomized pulse-train bench with a pulse-length reference decoder
module tb_b2s_receiver;
  import b2s_pkg::*;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        din;
  logic [31:0] dout;
  logic        dout_valid, frame_err, busy;
  int          checks = 0, errors = 0;
  int          nv = 0, ne = 0, nboth = 0;
  int          lo[32], hi[32];
  logic [31:0] exp_dout = '0;
  b2s_receiver dut (.clk(clk), .rst_n(rst_n), .b2s_din(din), .dout(dout),
                    .dout_valid(dout_valid), .frame_err(frame_err), .busy(busy));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (dout_valid) nv++;
    if (frame_err) ne++;
    if (dout_valid && frame_err) nboth++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic seg(input logic lvl, input int n);
    din = lvl;
    repeat (n) @(negedge clk);
  endtask
  task automatic set_tx(input logic [31:0] w);
    for (int i = 0; i < 32; i++) begin
      lo[i] = w[i] ? B2S_ONE_LOW : B2S_ZERO_LOW;
      hi[i] = w[i] ? B2S_ONE_HIGH : B2S_ZERO_HIGH;
    end
  endtask
  // reference decoder: works purely from the pulse lengths about to be driven
  task automatic predict(input int nbits, output logic [31:0] w, output logic e);
    w = '0;
    e = 1'b0;
    for (int i = 0; i < nbits && !e; i++)
      if (lo[i] >= B2S_MAX_LOW || (i < nbits - 1 && hi[i] >= B2S_IDLE_CYC)) e = 1'b1;
      else w[i] = lo[i] < B2S_THRESH;
    if (nbits < 32) e = 1'b1;
  endtask
  task automatic send(input int nbits, input int tail, input bit meas, input bit chk_busy, input string tag);
    int k;
    seg(0, B2S_START_LOW);
    if (chk_busy) chk({tag, "_busy_mid"}, busy, 1);
    seg(1, B2S_START_HIGH);
    for (int i = 0; i < nbits; i++) begin
      seg(0, lo[i]);
      if (i < nbits - 1) seg(1, hi[i]);
    end
    din = 1'b1;
    k = 0;
    if (meas) begin
      while (!dout_valid && k < 12) begin
        @(negedge clk);
        k++;
      end
      chk({tag, "_lat"}, k, 4);
    end
    seg(1, tail - k);
  endtask
  task automatic run(input string tag, input int nbits, input int pre_low, input int pre, input int tail);
    logic [31:0] w;
    logic        e;
    int          v0, e0;
    predict(nbits, w, e);
    v0 = nv;
    e0 = ne;
    seg(0, pre_low);
    seg(1, pre);
    send(nbits, tail, !e, 1'b1, tag);
    chk({tag, "_valid"}, nv - v0, e ? 0 : 1);
    chk({tag, "_err"}, ne - e0, e ? 1 : 0);
    if (!e) exp_dout = w;
    chk({tag, "_dout"}, dout, exp_dout);
    chk({tag, "_busy"}, busy, 0);
  endtask
  initial begin
    int v0, e0;
    din   = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dout", dout, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    set_tx(32'hA5A5_0F0F);
    v0 = nv;
    e0 = ne;
    seg(1, 100);
    send(32, 600, 1'b0, 1'b0, "early");
    chk("early_valid", nv - v0, 0);
    chk("early_err", ne - e0, 0);
    chk("early_busy", busy, 0);
    set_tx(32'hA5A5_0F0F);
    run("tx_a5a5", 32, 0, 550, hi[31]);
    for (int i = 0; i < 32; i++) begin lo[i] = 76; hi[i] = 20; end
    run("all76", 32, 0, 550, 40);
    for (int i = 0; i < 32; i++) begin lo[i] = i[0] ? 77 : 76; hi[i] = 20; end
    run("alt7677", 32, 0, 550, 40);
    set_tx(32'h0BAD_F00D);
    run("stuck_high", 10, 0, 550, 600);
    set_tx(32'h0BAD_F00D);
    lo[5] = 400;
    run("long_low", 6, 0, 550, 600);
    set_tx(32'h1234_5678);
    run("after_err", 32, 0, 550, hi[31]);
    set_tx(32'hCAFE_0123);
    seg(1, 550);
    send(16, 60, 1'b0, 1'b1, "partial");
    v0 = nv;
    e0 = ne;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_dout", dout, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", dout_valid, 0);
    chk("mid_rst_err", frame_err, 0);
    seg(1, 5);
    rst_n = 1'b1;
    seg(1, 20);
    chk("mid_rst_pulses", (nv - v0) + (ne - e0), 0);
    exp_dout = '0;
    set_tx(32'hDEAD_BEEF);
    run("deadbeef", 32, 0, 600, hi[31]);
    set_tx(32'h3C3C_A55A);
    run("b2b1", 32, 0, 550, hi[31]);
    set_tx(32'h0F1E_2D3C);
    run("b2b2", 32, 20, 1000, hi[31]);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 32; i++) begin
        lo[i] = $urandom_range(0, 1) ? int'($urandom_range(5, 76)) : int'($urandom_range(77, 200));
        hi[i] = int'($urandom_range(10, 120));
      end
      run($sformatf("rand%0d", r), 32, 0, 550, int'($urandom_range(20, 200)));
    end
    chk("excl", nboth, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
